// File: rtl/cim_pkg.sv
// Shared definitions for the CIM macro datapath blocks.
package cim_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

  // Ceiling log2 for sizing counters; clog2(1) = 0, clog2(8) = 3.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cim_shift_acc.sv
// Bit-serial shift-accumulator: weights one partial sum per activation bit
// plane (LSB plane first) by 2^k, subtracts the MSB plane for two's
// complement activations, and hands out one dot-product result per frame.
module cim_shift_acc
  import cim_pkg::*;
#(
  parameter  int PSUM_W  = 6,
  parameter  int IN_BITS = 8,
  localparam int ACC_W   = PSUM_W + IN_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] psum,
  input  logic              sus,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out
);

  localparam int CNT_W = (clog2(IN_BITS) > 1) ? clog2(IN_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_BITS - 1);

  acc_state_t               state;
  logic [CNT_W-1:0]         bit_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic                     signed_q;

  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic                     first_beat;
  logic                     last_beat;
  logic                     sub;

  // Sign- or zero-extend a partial sum to the full accumulator width.
  function automatic logic signed [ACC_W-1:0] extend_psum(
    input logic [PSUM_W-1:0] p,
    input logic              s
  );
    return {{IN_BITS{s & p[PSUM_W-1]}}, p};
  endfunction

  // Weight the current plane and fold it into the running sum; beat 0
  // restarts from zero and, for a one-plane frame, is also the MSB plane.
  always_comb begin
    first_beat = (bit_cnt == '0);
    last_beat  = (bit_cnt == LAST);
    term       = extend_psum(psum, sus) << bit_cnt;
    sub        = last_beat && (first_beat ? in_signed : signed_q);
    base       = first_beat ? '0 : acc;
    acc_nxt    = sub ? (base - term) : (base + term);
  end

  // Frame FSM: accumulate IN_BITS beats, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      bit_cnt  <= '0;
      acc      <= '0;
      signed_q <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc <= acc_nxt;
            if (first_beat) signed_q <= in_signed;
            if (last_beat) begin
              bit_cnt <= '0;
              state   <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign acc_out   = acc;

endmodule

// File: tb/tb_cim_shift_acc.sv
// Directed bench for cim_shift_acc at default parameters (ACC_W = 14).
module tb_cim_shift_acc;

  localparam int PSUM_W  = 6;
  localparam int IN_BITS = 8;
  localparam int ACC_W   = PSUM_W + IN_BITS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PSUM_W-1:0] psum = '0;
  logic              sus = 1'b0;
  logic              in_signed = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  acc_out;

  int n_vec = 0;
  int n_err = 0;

  cim_shift_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .psum      (psum),
    .sus       (sus),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*PSUM_W-1:0] psums;   // plane k at [6k +: 6]
    logic [7:0]          susv;    // sus per plane
    logic                sgn;     // in_signed on beat 0
    logic [ACC_W-1:0]    exp;
    int                  stall_at; // plane before which in_valid drops, -1 = none
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one frame at negedges; in_signed is inverted after beat 0 so the
  // result only matches if the beat-0 value is the one held for the frame.
  task automatic run_frame(input vec_t v, input logic release_now, input string tag);
    for (int k = 0; k < IN_BITS; k++) begin
      if (k == v.stall_at) begin
        in_valid = 1'b0;
        psum     = 6'h2A;
        repeat (3) @(negedge clk);
        chk({tag, "_stall_ready"}, 32'(in_ready), 32'd1);
      end
      in_valid  = 1'b1;
      psum      = v.psums[PSUM_W*k +: PSUM_W];
      sus       = v.susv[k];
      in_signed = (k == 0) ? v.sgn : ~v.sgn;
      if (k == IN_BITS - 1) chk({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_acc_out"},   32'(acc_out),   32'(v.exp));
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    if (release_now) begin
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_released"}, 32'(out_valid), 32'd0);
    end
  endtask

  function automatic logic [8*PSUM_W-1:0] fill(input logic [PSUM_W-1:0] p);
    return {IN_BITS{p}};
  endfunction

  vec_t vecs[7];
  vec_t v;

  initial begin
    // psum values and hand-computed results
    vecs[0] = '{fill(6'd1),  8'h00, 1'b0, 14'h00FF, -1};  // 255
    vecs[1] = '{fill(6'd1),  8'h00, 1'b1, 14'h3FFF, -1};  // 127-128 = -1
    vecs[2] = '{{6'h20, 42'd0}, 8'hFF, 1'b1, 14'h1000, -1}; // -32 * -128 = 4096
    vecs[3] = '{fill(6'd63), 8'h00, 1'b0, 14'h3EC1, -1};  // 63*255 = 16065
    vecs[4] = '{fill(6'h3F), 8'hFF, 1'b0, 14'h3F01, -1};  // -1*255 = -255
    vecs[5] = '{{6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0},
                8'h00, 1'b0, 14'h0602, 4};                  // sum k*2^k = 1538, stalled
    vecs[6] = '{fill(6'h3F), 8'h55, 1'b0, 14'h2981, -1};  // -85 + 63*170 = 10625

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_acc_out",   32'(acc_out),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    // backpressure: result held, beats offered in HOLD are not consumed
    out_ready = 1'b0;
    run_frame(vecs[0], 1'b0, "bp");
    in_valid = 1'b1;
    psum     = 6'd5;
    sus      = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_acc",   32'(acc_out),   32'h00FF);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(in_ready), 32'd1);
    v = '{fill(6'd5), 8'h00, 1'b0, 14'h04FB, -1};        // 5*255 = 1275
    run_frame(v, 1'b1, "bp_next");

    // reset mid-frame after four beats
    for (int k = 0; k < 4; k++) begin
      in_valid  = 1'b1;
      psum      = 6'd9;
      sus       = 1'b0;
      in_signed = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_acc",   32'(acc_out),   32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    run_frame(vecs[0], 1'b1, "after_rst");

    // reset while holding a result
    out_ready = 1'b0;
    run_frame(vecs[3], 1'b0, "hold_rst");
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    chk("hold_rst_valid", 32'(out_valid), 32'd0);
    chk("hold_rst_acc",   32'(acc_out),   32'd0);
    run_frame(vecs[1], 1'b1, "after_hold_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
